clock_period_meter: RTL and testbench

- Measures the period and high time of a slow, asynchronous square wave `sig_i` in `clk_i` cycles. It is the measuring end of the divided-clock path: it verifies divider outputs and off-board tick sources against the system clock.
- Results are published on a valid/ack handshake for the housekeeping register block.
- It flags a stopped input (timeout) and unread results that were overwritten (overrun).

---
 rtl/clock_period_meter_pkg.sv | 13 +
 rtl/sig_synchronizer.sv | 33 +++
 rtl/clock_period_meter.sv | 178 +++++++++++++++++
 tb/tb_clock_period_meter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: measurement states and
// default sizing.
package clock_period_meter_pkg;

  localparam int              DEFAULT_WIDTH   = 32;
  localparam longint unsigned DEFAULT_TIMEOUT = 1000000;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } meterState_e;

endpackage

// File: rtl/sig_synchronizer.sv
// sig_synchronizer: two-flop synchronizer for an asynchronous input plus a
// history flop, giving a clean level and single-cycle rise/fall strobes.
module sig_synchronizer (
  input  logic clk_i,
  input  logic reset_n,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Shift the input through two metastability stages and keep one cycle of history
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the period and high time of a slow asynchronous
// square wave in clk_i cycles, publishes each result on a valid/ack handshake,
// and flags a stopped input (timeout) and overwritten unread results (overrun).
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int              WIDTH   = DEFAULT_WIDTH,
  parameter longint unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             sig_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] MAX_C     = '1;
  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic sigLevel;
  logic sigRise;
  logic sigFall;

  meterState_e      state_q,   state_d;
  logic [WIDTH-1:0] pCnt_q,    pCnt_d;
  logic [WIDTH-1:0] hCnt_q,    hCnt_d;
  logic [WIDTH-1:0] hShadow_q, hShadow_d;
  logic             sawFall_q, sawFall_d;
  logic [WIDTH-1:0] period_q,  period_d;
  logic [WIDTH-1:0] high_q,    high_d;
  logic             valid_q,   valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic publish;
  logic risePublish;
  logic timeoutHit;
  logic pCntAtTimeout;

  sig_synchronizer uSync (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .sig_i   (sig_i),
    .level_o (sigLevel),
    .rise_o  (sigRise),
    .fall_o  (sigFall)
  );

  // Next-state logic for the measurement FSM, counters and result registers
  always_comb begin
    state_d       = state_q;
    pCnt_d        = pCnt_q;
    hCnt_d        = hCnt_q;
    hShadow_d     = hShadow_q;
    sawFall_d     = sawFall_q;
    period_d      = period_q;
    high_d        = high_q;
    publish       = 1'b0;
    risePublish   = 1'b0;
    timeoutHit    = 1'b0;
    pCntAtTimeout = (pCnt_q == TIMEOUT_C);

    unique case (state_q)
      WAIT_FIRST: begin
        if (sigRise) begin
          pCnt_d    = ONE_C;
          hCnt_d    = ONE_C;
          sawFall_d = 1'b0;
          state_d   = MEASURE;
        end else if (pCntAtTimeout) begin
          timeoutHit = 1'b1;
        end else begin
          pCnt_d = pCnt_q + ONE_C;
        end
      end

      MEASURE: begin
        pCnt_d = (pCnt_q == MAX_C) ? pCnt_q : pCnt_q + ONE_C;
        if (sigLevel && (hCnt_q != MAX_C)) begin
          hCnt_d = hCnt_q + ONE_C;
        end
        if (sigFall) begin
          hShadow_d = hCnt_q;
          sawFall_d = 1'b1;
        end
        if (sigRise) begin
          period_d    = pCnt_q;
          high_d      = sawFall_q ? hShadow_q : hCnt_q;
          pCnt_d      = ONE_C;
          hCnt_d      = ONE_C;
          sawFall_d   = 1'b0;
          publish     = 1'b1;
          risePublish = 1'b1;
        end else if (pCntAtTimeout) begin
          period_d   = '0;
          high_d     = '0;
          pCnt_d     = '0;
          publish    = 1'b1;
          timeoutHit = 1'b1;
          state_d    = WAIT_FIRST;
        end
      end

      default: begin
        state_d = WAIT_FIRST;
        pCnt_d  = '0;
      end
    endcase
  end

  // State, counter and result registers; reset discards any measurement in flight
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_FIRST;
      pCnt_q    <= '0;
      hCnt_q    <= '0;
      hShadow_q <= '0;
      sawFall_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
    end else begin
      state_q   <= state_d;
      pCnt_q    <= pCnt_d;
      hCnt_q    <= hCnt_d;
      hShadow_q <= hShadow_d;
      sawFall_q <= sawFall_d;
      period_q  <= period_d;
      high_q    <= high_d;
    end
  end

  // Handshake flags: a publish beats a same-cycle ack, and overrun marks lost results
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    if (ack_i) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (publish) begin
      valid_d = 1'b1;
      if (valid_q && !ack_i) begin
        overrun_d = 1'b1;
      end
    end
    if (timeoutHit) begin
      timeout_d = 1'b1;
    end else if (risePublish) begin
      timeout_d = 1'b0;
    end
  end

  // Handshake flag registers
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Testbench for clock_period_meter: a clk_i-synchronous divider drives sig_i,
// expected results are queued when a waveform is set up and compared when the
// meter publishes them.
module tb_clock_period_meter;

  localparam int WIDTH      = 32;
  localparam int TB_TIMEOUT = 20;

  typedef struct {
    int unsigned period;
    int unsigned high;
    bit          tmo;
    bit          ovr;
  } result_t;

  logic             clk_i   = 1'b0;
  logic             reset_n = 1'b0;
  logic             sig_i;
  logic             ack_i   = 1'b0;
  logic [WIDTH-1:0] period_o;
  logic [WIDTH-1:0] high_o;
  logic             valid_o;
  logic             overrun_o;
  logic             timeout_o;

  int      totalChecks = 0;
  int      passCount   = 0;
  result_t sbQ[$];

  int genDiv      = 3;
  int genHigh     = 1;
  bit genEnable   = 1'b0;
  bit genStop     = 1'b0;
  int riseCount   = 0;
  int cycCount    = 0;
  int lastRiseCyc = 0;
  int lastSeenCyc = 0;

  clock_period_meter #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .sig_i     (sig_i),
    .ack_i     (ack_i),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .overrun_o (overrun_o),
    .timeout_o (timeout_o)
  );

  // 10 ns system clock
  initial begin
    forever #5 clk_i = ~clk_i;
  end

  // Cycle counter used to time the stopped-input report
  always @(posedge clk_i) begin
    cycCount <= cycCount + 1;
  end

  // Divide-by-N waveform (low phase first), driven 2 ns after each clock edge
  initial begin
    int  genCnt;
    bit  halted;
    bit  prevSig;
    genCnt  = 0;
    halted  = 1'b0;
    prevSig = 1'b0;
    sig_i   = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!genEnable) begin
        genCnt = 0;
        halted = 1'b0;
        sig_i  = 1'b0;
      end else if (halted) begin
        sig_i = 1'b0;
      end else begin
        sig_i = (genCnt >= genDiv - genHigh);
        if (genCnt == genDiv - 1) begin
          genCnt = 0;
          if (genStop) halted = 1'b1;
        end else begin
          genCnt++;
        end
      end
      if (sig_i && !prevSig) begin
        riseCount++;
        lastRiseCyc = cycCount;
      end
      prevSig = sig_i;
    end
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Pop the oldest expected result and compare it with the published outputs
  task automatic checkResult();
    result_t exp;
    checkOutput("sbNonEmpty", 64'(sbQ.size() != 0), 64'd1);
    if (sbQ.size() != 0) begin
      exp = sbQ.pop_front();
      checkOutput("valid",   64'(valid_o),   64'd1);
      checkOutput("period",  64'(period_o),  64'(exp.period));
      checkOutput("high",    64'(high_o),    64'(exp.high));
      checkOutput("timeout", 64'(timeout_o), 64'(exp.tmo));
      checkOutput("overrun", 64'(overrun_o), 64'(exp.ovr));
    end
  endtask

  // Wait (bounded) for valid_o, check the result, optionally acknowledge it
  task automatic waitResult(input bit doAck, input int budget);
    int n = 0;
    while (valid_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    lastSeenCyc = cycCount;
    checkResult();
    if (doAck) begin
      ack_i = 1'b1;
      @(negedge clk_i);
      ack_i = 1'b0;
      checkOutput("ackClearsValid", 64'(valid_o), 64'd0);
    end
  endtask

  // Reset the meter and restart the divider cleanly in its low phase
  task automatic applyStimulus(input int div, input int high);
    genEnable = 1'b0;
    ack_i     = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk_i);
    genDiv    = div;
    genHigh   = high;
    genStop   = 1'b0;
    genEnable = 1'b1;
    @(negedge clk_i);
    reset_n   = 1'b1;
  endtask

  // Abort guard in case the run stops making progress
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;

    $display("[TB] reset held with sig_i toggling");
    genDiv    = 3;
    genHigh   = 1;
    genEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk_i);
      checkOutput("rstValid",  64'(valid_o),  64'd0);
      checkOutput("rstPeriod", 64'(period_o), 64'd0);
    end
    checkOutput("rstHigh",    64'(high_o),    64'd0);
    checkOutput("rstOverrun", 64'(overrun_o), 64'd0);
    checkOutput("rstTimeout", 64'(timeout_o), 64'd0);

    $display("[TB] divide-by-5, first rise must not publish");
    applyStimulus(5, 3);
    base = riseCount;
    n = 0;
    while (riseCount == base && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    repeat (4) @(negedge clk_i);
    checkOutput("noResultFirstRise", 64'(valid_o), 64'd0);
    sbQ.push_back('{5, 3, 1'b0, 1'b0});
    waitResult(1'b1, 20);
    checkOutput("twoRisesNeeded", 64'((riseCount - base) >= 2), 64'd1);
    sbQ.push_back('{5, 3, 1'b0, 1'b0});
    waitResult(1'b1, 20);

    $display("[TB] divide-by-6, unacknowledged results");
    applyStimulus(6, 3);
    sbQ.push_back('{6, 3, 1'b0, 1'b0});
    waitResult(1'b0, 30);
    sbQ.push_back('{6, 3, 1'b0, 1'b1});
    repeat (6) @(negedge clk_i);
    checkResult();
    sbQ.push_back('{6, 3, 1'b0, 1'b0});
    repeat (5) @(negedge clk_i);
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    checkResult();
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    checkOutput("ackAfterCoincide", 64'(valid_o), 64'd0);

    $display("[TB] divide-by-4 then stopped input");
    applyStimulus(4, 2);
    sbQ.push_back('{4, 2, 1'b0, 1'b0});
    waitResult(1'b1, 20);
    genStop = 1'b1;
    sbQ.push_back('{4, 2, 1'b0, 1'b0});
    waitResult(1'b1, 20);
    sbQ.push_back('{0, 0, 1'b1, 1'b0});
    waitResult(1'b1, 40);
    checkOutput("timeoutLatency", 64'((lastSeenCyc - lastRiseCyc) <= TB_TIMEOUT + 3), 64'd1);
    genEnable = 1'b0;
    @(negedge clk_i);
    genStop   = 1'b0;
    genDiv    = 4;
    genHigh   = 2;
    genEnable = 1'b1;
    checkOutput("timeoutSticky", 64'(timeout_o), 64'd1);
    sbQ.push_back('{4, 2, 1'b0, 1'b0});
    waitResult(1'b1, 40);

    $display("[TB] asynchronous reset pulse mid-period");
    applyStimulus(5, 3);
    sbQ.push_back('{5, 3, 1'b0, 1'b0});
    waitResult(1'b0, 30);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRstValid",   64'(valid_o),   64'd0);
    checkOutput("asyncRstPeriod",  64'(period_o),  64'd0);
    checkOutput("asyncRstHigh",    64'(high_o),    64'd0);
    checkOutput("asyncRstOverrun", 64'(overrun_o), 64'd0);
    checkOutput("asyncRstTimeout", 64'(timeout_o), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_i);
    base = riseCount;
    repeat (6) @(negedge clk_i);
    checkOutput("noResultAfterReset", 64'(valid_o), 64'd0);
    sbQ.push_back('{5, 3, 1'b0, 1'b0});
    waitResult(1'b1, 20);
    checkOutput("freshRisesNeeded", 64'((riseCount - base) >= 2), 64'd1);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
